// File: rtl/spi_reg_pkg.sv
// Shared constants and controller state encoding for the SPI register-access block.
package spi_reg_pkg;

  localparam int AW         = 7;
  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int CNT_W      = $clog2(BYTE_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_TURN  = 3'd2,
    ST_RDATA = 3'd3,
    ST_WDATA = 3'd4
  } state_t;

endpackage

// File: rtl/spi_rx_byte.sv
// SPI byte deserialiser: one MOSI bit per clk while ss is low, MSB first.
module spi_rx_byte
  import spi_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss,
  input  logic              mosi,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              dv,
  output logic              last_bit
);

  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] sr;
  logic [BYTE_W-1:0] sr_next;

  assign sr_next  = {sr[BYTE_W-2:0], mosi};
  assign last_bit = (bit_cnt == CNT_W'(BYTE_W - 1)) && !ss;

  // dv is a registered pulse, high only in the cycle after the eighth bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      sr      <= '0;
      rx_byte <= '0;
      dv      <= 1'b0;
    end else begin
      dv <= 1'b0;
      if (ss) begin
        bit_cnt <= '0;
        sr      <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        sr      <= sr_next;
        if (last_bit) begin
          rx_byte <= sr_next;
          dv      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI slave that turns {rw, addr} command frames into register writes or streamed reads
// with auto-incrementing address.
module spi_reg_ctrl #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ss,
  input  logic          mosi,
  output logic          miso,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          busy,
  output logic          frame_err
);
  import spi_reg_pkg::*;

  state_t            state;
  state_t            state_next;
  logic [BYTE_W-1:0] rx_byte;
  logic [BYTE_W-1:0] tx_sr;
  logic [AW-1:0]     addr;
  logic              dv;
  logic              last_bit;
  logic              mid_byte;

  spi_rx_byte u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss       (ss),
    .mosi     (mosi),
    .rx_byte  (rx_byte),
    .dv       (dv),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!ss) state_next = ST_CMD;
      ST_CMD: begin
        if (ss)      state_next = ST_IDLE;
        else if (dv) state_next = rx_byte[CMD_RW_BIT] ? ST_TURN : ST_WDATA;
      end
      ST_TURN: begin
        if (ss)            state_next = ST_IDLE;
        else if (last_bit) state_next = ST_RDATA;
      end
      ST_RDATA: if (ss) state_next = ST_IDLE;
      ST_WDATA: if (ss) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    miso = (state == ST_RDATA) ? tx_sr[BYTE_W-1] : 1'b0;
  end

  // A dv arriving with ss already high still completes its write; mid_byte records
  // whether the bit counter is away from a byte boundary, for abort detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      rd_addr   <= '0;
      tx_sr     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      mid_byte  <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_err <= ss && mid_byte;
      mid_byte  <= !ss && !last_bit;

      if (state == ST_CMD && dv && !ss) begin
        addr <= rx_byte[AW-1:0];
        if (rx_byte[CMD_RW_BIT]) rd_addr <= rx_byte[AW-1:0];
      end

      if (state == ST_WDATA && dv) begin
        wr_en   <= 1'b1;
        wr_addr <= addr;
        wr_data <= rx_byte;
        addr    <= addr + AW'(1);
      end

      if (ss) begin
        tx_sr <= '0;
      end else if ((state == ST_TURN || state == ST_RDATA) && last_bit) begin
        tx_sr   <= rd_data;
        rd_addr <= rd_addr + AW'(1);
      end else if (state == ST_RDATA) begin
        tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
      end
    end
  end

endmodule
